// File: rtl/keccak_unpadder.sv
// ---------------------------------------------------------------------------
// keccak_unpadder
//
// Receive-side inverse of the SHA-3 32-bit pad stage. Words of non-final
// rate blocks pass straight through. In the final block the 0x01 ... 0x80
// pad is stripped. Only message bytes are emitted. The last message word
// carries is_last/byte_num with the same encoding the pad stage consumes.
//
// Because a word of the form "..01 00 00" might be either the pad start or
// ordinary data, such a candidate is held back. Any following all-zero
// words are only counted. If the last word of the block arrives while
// still holding, the candidate was the pad start. If a non-zero word
// arrives first, the candidate and the counted zeros are replayed as plain
// data.
//
// Ports
//   clk, reset            clock (rising edge) and async active-high reset
//   in, in_valid,         padded input word (byte 0 = in[31:24]), valid,
//   in_final, in_ready    final-block marker and combinational ready
//   out, out_valid,       registered message word, valid,
//   out_ready             sink ready
//   is_last, byte_num     last message word marker / valid byte count 0..3
//   pad_error             sticky malformed-padding flag
// ---------------------------------------------------------------------------
module keccak_unpadder #(
    parameter int RATE_WORDS = 34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in,
    input  logic        in_valid,
    input  logic        in_final,
    output logic        in_ready,
    output logic [31:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        is_last,
    output logic [1:0]  byte_num,
    output logic        pad_error
);

    typedef enum logic [1:0] {
        ST_PASS,
        ST_HOLD,
        ST_REPLAY,
        ST_DONE
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(RATE_WORDS - 1);

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  zcnt_q, zcnt_d;
    logic [31:0] cand_q, cand_d;
    logic [1:0]  k_q, k_d;
    logic        replay_first_q, replay_first_d;
    logic [31:0] out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic        is_last_q, is_last_d;
    logic [1:0]  byte_num_q, byte_num_d;
    logic        pad_error_q, pad_error_d;

    logic        at_last_idx;
    logic        load_ok;
    logic        accept;
    logic [31:0] word_c;
    logic        is_zero;
    logic        is_cand;
    logic [1:0]  cand_k;

    // Zero bytes k..3 of a word, leaving only the message bytes before the
    // pad start.
    function automatic logic [31:0] strip_pad(input logic [31:0] w, input logic [1:0] k);
        logic [31:0] r;
        case (k)
            2'd0:    r = 32'h0000_0000;
            2'd1:    r = w & 32'hFF00_0000;
            2'd2:    r = w & 32'hFFFF_0000;
            default: r = w & 32'hFFFF_FF00;
        endcase
        return r;
    endfunction

    // Word classification. The final word of a final block has its closing
    // 0x80 bit removed before it is classified. Candidates are searched from
    // byte 3 down so that at most one k can match.
    always_comb begin
        at_last_idx = (idx_q == LAST_IDX);
        word_c      = in;
        if (in_final && at_last_idx) begin
            word_c[7] = 1'b0;
        end
        is_zero = (word_c == 32'h0000_0000);
        is_cand = 1'b0;
        cand_k  = 2'd0;
        if (word_c[7:0] == 8'h01) begin
            is_cand = 1'b1;
            cand_k  = 2'd3;
        end else if (word_c[7:0] == 8'h00 && word_c[15:8] == 8'h01) begin
            is_cand = 1'b1;
            cand_k  = 2'd2;
        end else if (word_c[15:0] == 16'h0000 && word_c[23:16] == 8'h01) begin
            is_cand = 1'b1;
            cand_k  = 2'd1;
        end else if (word_c[23:0] == 24'h00_0000 && word_c[31:24] == 8'h01) begin
            is_cand = 1'b1;
            cand_k  = 2'd0;
        end
    end

    // Next-state and output-register logic. The single output register may
    // only be reloaded once its current word has been taken, or if it is empty.
    always_comb begin
        load_ok        = !out_valid_q || out_ready;
        in_ready       = 1'b0;
        accept         = 1'b0;
        state_d        = state_q;
        idx_d          = idx_q;
        zcnt_d         = zcnt_q;
        cand_d         = cand_q;
        k_d            = k_q;
        replay_first_d = replay_first_q;
        out_d          = out_q;
        out_valid_d    = out_valid_q && !out_ready;
        is_last_d      = is_last_q;
        byte_num_d     = byte_num_q;
        pad_error_d    = pad_error_q;

        case (state_q)
            ST_PASS: begin
                in_ready = load_ok;
                accept   = in_valid && in_ready;
                if (accept) begin
                    idx_d = at_last_idx ? 6'd0 : idx_q + 6'd1;
                    if (!in_final) begin
                        out_d       = in;
                        out_valid_d = 1'b1;
                        is_last_d   = 1'b0;
                        byte_num_d  = 2'd0;
                    end else begin
                        if (at_last_idx && !in[7]) begin
                            pad_error_d = 1'b1;
                        end
                        if (is_cand && at_last_idx) begin
                            out_d       = strip_pad(word_c, cand_k);
                            out_valid_d = 1'b1;
                            is_last_d   = 1'b1;
                            byte_num_d  = cand_k;
                            state_d     = ST_DONE;
                        end else if (is_cand) begin
                            cand_d  = word_c;
                            k_d     = cand_k;
                            zcnt_d  = 6'd0;
                            state_d = ST_HOLD;
                        end else if (at_last_idx) begin
                            // No pad start anywhere in the block.
                            pad_error_d = 1'b1;
                            out_d       = 32'h0000_0000;
                            out_valid_d = 1'b1;
                            is_last_d   = 1'b1;
                            byte_num_d  = 2'd0;
                            state_d     = ST_DONE;
                        end else begin
                            out_d       = word_c;
                            out_valid_d = 1'b1;
                            is_last_d   = 1'b0;
                            byte_num_d  = 2'd0;
                        end
                    end
                end
            end

            ST_HOLD: begin
                // A non-zero word is left on the input. It is processed in PASS
                // once the held words have been replayed.
                in_ready = load_ok && is_zero;
                accept   = in_valid && in_ready;
                if (accept) begin
                    idx_d = at_last_idx ? 6'd0 : idx_q + 6'd1;
                    if (at_last_idx) begin
                        if (!in[7]) begin
                            pad_error_d = 1'b1;
                        end
                        out_d       = strip_pad(cand_q, k_q);
                        out_valid_d = 1'b1;
                        is_last_d   = 1'b1;
                        byte_num_d  = k_q;
                        state_d     = ST_DONE;
                    end else begin
                        zcnt_d = zcnt_q + 6'd1;
                    end
                end else if (in_valid && !is_zero) begin
                    replay_first_d = 1'b1;
                    state_d        = ST_REPLAY;
                end
            end

            ST_REPLAY: begin
                if (load_ok) begin
                    out_valid_d = 1'b1;
                    is_last_d   = 1'b0;
                    byte_num_d  = 2'd0;
                    if (replay_first_q) begin
                        out_d          = cand_q;
                        replay_first_d = 1'b0;
                        if (zcnt_q == 6'd0) begin
                            state_d = ST_PASS;
                        end
                    end else begin
                        out_d  = 32'h0000_0000;
                        zcnt_d = zcnt_q - 6'd1;
                        if (zcnt_q == 6'd1) begin
                            state_d = ST_PASS;
                        end
                    end
                end
            end

            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    idx_d   = 6'd0;
                    state_d = ST_PASS;
                end
            end

            default: begin
                state_d = ST_PASS;
            end
        endcase
    end

    // State and output registers; reset discards any partial block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_PASS;
            idx_q          <= 6'd0;
            zcnt_q         <= 6'd0;
            cand_q         <= 32'h0000_0000;
            k_q            <= 2'd0;
            replay_first_q <= 1'b0;
            out_q          <= 32'h0000_0000;
            out_valid_q    <= 1'b0;
            is_last_q      <= 1'b0;
            byte_num_q     <= 2'd0;
            pad_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            zcnt_q         <= zcnt_d;
            cand_q         <= cand_d;
            k_q            <= k_d;
            replay_first_q <= replay_first_d;
            out_q          <= out_d;
            out_valid_q    <= out_valid_d;
            is_last_q      <= is_last_d;
            byte_num_q     <= byte_num_d;
            pad_error_q    <= pad_error_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign is_last   = is_last_q;
    assign byte_num  = byte_num_q;
    assign pad_error = pad_error_q;

endmodule

// File: tb/tb_keccak_unpadder.sv
// ---------------------------------------------------------------------------
// tb_keccak_unpadder
//
// Directed bench for keccak_unpadder. Final blocks that differ only in
// words 0, 1 and 33 are described in a vector table. Longer cases are
// written out by hand: pass-through, replay stall, sticky error, and reset
// while holding.
// ---------------------------------------------------------------------------
module tb_keccak_unpadder;

    localparam int RW = 34;

    logic        clk;
    logic        reset;
    logic [31:0] in;
    logic        in_valid;
    logic        in_final;
    logic        in_ready;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        is_last;
    logic [1:0]  byte_num;
    logic        pad_error;

    keccak_unpadder #(.RATE_WORDS(RW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .in_final  (in_final),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .is_last   (is_last),
        .byte_num  (byte_num),
        .pad_error (pad_error)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  bn;
        int          cyc;
    } cap_t;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w33;
        int          exp_count;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        logic [1:0]  exp_bn;
        logic        exp_err;
    } vec_t;

    cap_t        caps[$];
    logic [31:0] blk[RW];
    int          stall[RW];
    int          cyc;
    int          passed;
    int          total;

    // Free-running clock and cycle counter used for throughput measurement.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Record every output handshake, sampled well away from the rising edge.
    always begin
        @(negedge clk);
        #2;
        if (!reset && out_valid && out_ready) begin
            caps.push_back('{out, is_last, byte_num, cyc});
        end
    end

    // Hard stop in case something wedges outside a bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Offer blk[first .. first+n-1] one at a time, recording stall cycles per word.
    task automatic applyStimulus(input int first, input int n, input logic fin);
        for (int i = first; i < first + n; i++) begin
            int  waited;
            bit  done;
            waited = 0;
            done   = 1'b0;
            while (!done) begin
                @(negedge clk);
                in       = blk[i];
                in_valid = 1'b1;
                in_final = fin;
                #1;
                if (in_ready) begin
                    done = 1'b1;
                end else begin
                    waited++;
                    if (waited > 200) begin
                        total++;
                        $display("[TB] FAIL accept_timeout word %0d: got no in_ready, expected in_ready", i);
                        done = 1'b1;
                    end
                end
            end
            stall[i] = waited;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in       = 32'h0;
    endtask

    task automatic drain();
        repeat (5) @(negedge clk);
    endtask

    task automatic loadFinal(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w33);
        for (int i = 0; i < RW; i++) blk[i] = 32'h0;
        blk[0]  = w0;
        blk[1]  = w1;
        blk[33] = w33;
    endtask

    task automatic runNonFinal(input string tag);
        int bad;
        int stalls;
        for (int i = 0; i < RW; i++) blk[i] = 32'(i + 1);
        caps.delete();
        applyStimulus(0, RW, 1'b0);
        drain();
        checkOutput({tag, "_count"}, caps.size(), RW);
        bad = 0;
        for (int i = 0; i < caps.size(); i++) begin
            if (caps[i].data !== 32'(i + 1) || caps[i].last !== 1'b0) bad++;
        end
        checkOutput({tag, "_word_errors"}, bad, 0);
        stalls = 0;
        for (int i = 0; i < RW; i++) stalls += stall[i];
        checkOutput({tag, "_input_stalls"}, stalls, 0);
        if (caps.size() == RW) begin
            checkOutput({tag, "_cycle_span"}, caps[RW-1].cyc - caps[0].cyc, RW - 1);
        end
    endtask

    task automatic runVector(input string tag, input vec_t v);
        int n;
        int stray;
        loadFinal(v.w0, v.w1, v.w33);
        caps.delete();
        applyStimulus(0, RW, 1'b1);
        drain();
        n = caps.size();
        checkOutput({tag, "_count"}, n, v.exp_count);
        if (n > 0) begin
            checkOutput({tag, "_first"}, caps[0].data, v.exp_first);
            checkOutput({tag, "_last_word"}, caps[n-1].data, v.exp_last);
            checkOutput({tag, "_is_last"}, caps[n-1].last, 1'b1);
            checkOutput({tag, "_byte_num"}, caps[n-1].bn, v.exp_bn);
            stray = 0;
            for (int i = 0; i < n - 1; i++) if (caps[i].last !== 1'b0) stray++;
            checkOutput({tag, "_early_is_last"}, stray, 0);
        end
        checkOutput({tag, "_pad_error"}, pad_error, v.exp_err);
    endtask

    vec_t vecs[6];

    initial begin
        passed    = 0;
        total     = 0;
        reset     = 1'b1;
        in        = 32'h0;
        in_valid  = 1'b0;
        in_final  = 1'b0;
        out_ready = 1'b1;

        // Final-block vectors: words 2..32 are zero.
        vecs[0] = '{32'h11223344, 32'h11220100, 32'h00000080,  2, 32'h11223344, 32'h11220000, 2'd2, 1'b0};
        vecs[1] = '{32'h11223344, 32'hDEADBEEF, 32'h11223381, 34, 32'h11223344, 32'h11223300, 2'd3, 1'b0};
        vecs[2] = '{32'h00000001, 32'h00000000, 32'h00000080,  1, 32'h00000000, 32'h00000000, 2'd3, 1'b0};
        vecs[3] = '{32'hCAFEF00D, 32'h00000000, 32'h01000080, 34, 32'hCAFEF00D, 32'h00000000, 2'd0, 1'b0};
        vecs[4] = '{32'h00000001, 32'h00000100, 32'h00000080,  2, 32'h00000001, 32'h00000000, 2'd2, 1'b0};
        vecs[5] = '{32'h12345678, 32'h00000000, 32'h00000000, 34, 32'h12345678, 32'h00000000, 2'd0, 1'b1};

        #2;
        checkOutput("reset_out", out, 32'h0);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_is_last", is_last, 1'b0);
        checkOutput("reset_byte_num", byte_num, 2'd0);
        checkOutput("reset_pad_error", pad_error, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] non-final pass-through block");
        runNonFinal("nonfinal");

        $display("[TB] replay stall block");
        for (int i = 0; i < RW; i++) blk[i] = 32'h0;
        blk[0]  = 32'hAA010000;
        blk[2]  = 32'h55000000;
        blk[3]  = 32'h01000000;
        blk[33] = 32'h00000080;
        caps.delete();
        applyStimulus(0, RW, 1'b1);
        drain();
        checkOutput("replay_count", caps.size(), 4);
        if (caps.size() == 4) begin
            checkOutput("replay_w0", caps[0].data, 32'hAA010000);
            checkOutput("replay_w1", caps[1].data, 32'h00000000);
            checkOutput("replay_w2", caps[2].data, 32'h55000000);
            checkOutput("replay_w3", caps[3].data, 32'h00000000);
            checkOutput("replay_flags", {caps[0].last, caps[1].last, caps[2].last, caps[3].last}, 4'b0001);
            checkOutput("replay_byte_num", caps[3].bn, 2'd0);
        end
        checkOutput("replay_stall_w1", stall[1], 0);
        checkOutput("replay_stall_w2", stall[2], 3);

        $display("[TB] final-block vector table");
        for (int i = 0; i < 6; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        $display("[TB] pad_error stickiness");
        runNonFinal("after_err");
        checkOutput("sticky_pad_error", pad_error, 1'b1);

        $display("[TB] reset while holding");
        for (int i = 0; i < RW; i++) blk[i] = 32'h0;
        blk[0] = 32'h01000000;
        out_ready = 1'b1;
        caps.delete();
        applyStimulus(0, 1, 1'b1);
        out_ready = 1'b0;
        applyStimulus(1, 5, 1'b1);
        checkOutput("hold_no_output", caps.size(), 0);
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midreset_out_valid", out_valid, 1'b0);
        checkOutput("midreset_pad_error", pad_error, 1'b0);
        checkOutput("midreset_is_last", is_last, 1'b0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        runVector("post_reset", vecs[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/keccak_unpadder.md
Name: keccak_unpadder

Overview:
- Receive-side inverse of the SHA-3 32-bit pad path. Accepts a stream of 32-bit rate-block words and passes non-final blocks through unchanged.
- In the final block, strips the 0x01…0x80 pad and emits only message bytes. The last message word carries is_last and byte_num, using the same encoding the pad stage consumes.
- Sits between the block-level receive buffer and the message sink.

Parameters:
RATE_WORDS, 34, 32-bit words per rate block (1088 bits); index counter is 6 bits wide.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
in  input  32  padded word; byte 0 = in[31:24], byte 3 = in[7:0]
in_valid  input  1  in word present
in_final  input  1  word belongs to final block; constant for the whole block
in_ready  output  1  word accepted when in_valid && in_ready
out  output  32  message word; bytes at and after pad start are zero
out_valid  output  1  out holds a word
out_ready  input  1  sink accepts when out_valid && out_ready
is_last  output  1  out is last message word
byte_num  output  2  valid bytes in out when is_last (0..3); 0 = no bytes
pad_error  output  1  sticky malformed-padding flag; cleared only by reset

Behaviour:
- Reset values:
  - out=0, out_valid=0, is_last=0, byte_num=0, pad_error=0.
  - Word index=0, zcnt=0, cand=0, state=PASS.
- Output register is single-entry. A new word may be loaded only when out_valid=0 or out_ready=1.
- in_ready is combinational and may depend on in; in_ready=0 whenever the output register cannot load.
- Word index increments on each accepted word and wraps to 0 after RATE_WORDS-1.
- Non-final blocks:
  - Every word is copied to out one cycle after acceptance, with is_last=0.
  - Sustained throughput is 1 word/cycle.
- Final block, word classification:
  - For word RATE_WORDS-1, in[7] must be 1. If it is 0, set pad_error. Clear bit 7 before classifying.
  - "candidate k": byte k == 0x01 and bytes k+1..3 all zero. This k is unique.
  - "zero": all bytes 0.
  - "data": anything else.
- States:
  - PASS:
    - data or zero word: emit word, is_last=0.
    - candidate word: latch cand=word, k, zcnt=0 -> HOLD; nothing emitted.
    - candidate on last index: emit immediately with is_last=1, byte_num=k, bytes k..3 zeroed -> DONE.
  - HOLD:
    - zero word: accept, zcnt++, nothing emitted.
    - zero word on last index: accept, emit cand with is_last=1, byte_num=k, bytes k..3 zeroed -> DONE.
    - data or candidate word: in_ready=0 (word not consumed) -> REPLAY.
  - REPLAY:
    - Emit cand unmodified, then zcnt zero words, one per output handshake, all with is_last=0.
    - Then go to PASS; PASS processes the stalled word.
  - DONE: one cycle after is_last is handshaked, index=0 -> PASS.
- Error:
  - Reaching last index in PASS with a non-candidate word sets pad_error.
  - That word is emitted with is_last=1, byte_num=0, out=0.
- Block-boundary handling:
  - zcnt is at most RATE_WORDS-2; no overflow handling is needed.
  - in_final changing mid-block is illegal; the block is undefined and no check is made.
- Reset during any state aborts immediately. Partial block and pending cand are discarded.

Test Plan:
- Non-final block of 34 words 0x00000001..0x00000022, out_ready=1 -> 34 words out unchanged, is_last=0, one per cycle.
- Final block: word0=0x11223344, word1=0x11220100, words2..32=0, word33=0x00000080 -> out 0x11223344, then 0x11220000 with is_last=1, byte_num=2; 2 words total.
- Final block, word0=0xAA010000, word1=0x00000000, word2=0x55000000, word3=0x01000000, zeros, word33=0x80 -> out 0xAA010000, 0, 0x55000000, then 0x00000000 with is_last=1, byte_num=0; stall visible on word2.
- Single-pad-byte case: word33=0x11223381, all earlier words data -> last out 0x11223300 with is_last=1, byte_num=3.
- Final block with word33=0x00000000 -> pad_error=1 and remains 1 through the next blocks until reset.
- Reset asserted while in HOLD with zcnt=5, out_ready=0 -> out_valid=0 and pad_error=0 asynchronously; a following clean block decodes correctly.
